// File: rtl/j1_uart.sv
// Memory-mapped 8N1 UART for the J1 I/O bus: DATA/STATUS/DIV registers with
// combinational read data, and small TX/RX byte FIFOs in front of the serial FSMs.

module j1_uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       empty_o,
  output logic       full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign rdata_o = mem_q[rp_q];
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a push when the same cycle frees a slot.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wp_q] <= wdata_i;
  end
endmodule

module j1_uart #(
  parameter logic [15:0] BASE       = 16'hF000,
  parameter logic [15:0] DIV_RESET  = 16'd433,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  input  logic        uart_rxd_i,
  output logic        uart_txd_o
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic        sel;
  logic [1:0]  off;
  logic        unused_addr0;
  logic [15:0] div_q, div_eff, half;
  logic        ovr_q, fe_q;
  logic        ovr_set, fe_set, stat_clr;

  logic       tx_push, tx_pop, tx_empty, tx_full;
  logic [7:0] tx_rdata;
  logic       rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0] rx_rdata;

  state_e      tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        txd_q, txd_d;

  state_e      rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [1:0]  sync_q;
  logic        rx_prev_q, rx_s;

  assign sel          = (io_addr[15:3] == BASE[15:3]);
  assign off          = io_addr[2:1];
  assign unused_addr0 = io_addr[0];
  assign tx_push      = io_wr && sel && (off == 2'd0) && !tx_full;
  assign rx_pop       = io_rd && sel && (off == 2'd0);
  assign stat_clr     = io_rd && sel && (off == 2'd1);

  // Divisors below 3 are clamped so the half-bit START wait is never zero.
  assign div_eff    = (div_q < 16'd3) ? 16'd3 : div_q;
  assign half       = {1'b0, div_eff[15:1]} + {15'b0, div_eff[0]};
  assign rx_s       = sync_q[1];
  assign uart_txd_o = txd_q;

  j1_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_txf (
    .clk_i(sys_clk_i), .rst_i(sys_rst_i), .push_i(tx_push), .pop_i(tx_pop),
    .wdata_i(io_dout[7:0]), .rdata_o(tx_rdata), .empty_o(tx_empty), .full_o(tx_full)
  );

  j1_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rxf (
    .clk_i(sys_clk_i), .rst_i(sys_rst_i), .push_i(rx_push), .pop_i(rx_pop),
    .wdata_i(rx_sh_d), .rdata_o(rx_rdata), .empty_o(rx_empty), .full_o(rx_full)
  );

  always_comb begin
    io_din = 16'h0000;
    if (sel) begin
      case (off)
        2'd0:    io_din = rx_empty ? 16'h0000 : {8'h00, rx_rdata};
        2'd1:    io_din = {11'b0, tx_empty && (tx_st_q == S_IDLE), fe_q, ovr_q,
                           !tx_full, !rx_empty};
        2'd2:    io_din = div_q;
        default: io_din = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      div_q     <= DIV_RESET;
      ovr_q     <= 1'b0;
      fe_q      <= 1'b0;
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      if (io_wr && sel && (off == 2'd2)) div_q <= io_dout;
      ovr_q     <= ovr_set | (ovr_q & ~stat_clr);
      fe_q      <= fe_set | (fe_q & ~stat_clr);
      sync_q    <= {sync_q[0], uart_rxd_i};
      rx_prev_q <= rx_s;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      tx_st_q  <= S_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      txd_q    <= 1'b1;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      txd_q    <= txd_d;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    tx_sh_q <= tx_sh_d;
    rx_sh_q <= rx_sh_d;
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    txd_d    = txd_q;
    tx_pop   = 1'b0;
    case (tx_st_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!tx_empty) begin
          tx_pop   = 1'b1;
          tx_sh_d  = tx_rdata;
          tx_cnt_d = div_eff;
          txd_d    = 1'b0;
          tx_st_d  = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == '0) begin
          tx_st_d  = S_DATA;
          txd_d    = tx_sh_q[0];
          tx_bit_d = 3'd0;
          tx_cnt_d = div_eff;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      S_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = div_eff;
          if (tx_bit_q == 3'd7) begin
            tx_st_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1;
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            txd_d    = tx_sh_q[1];
          end
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      S_STOP: begin
        if (tx_cnt_q == '0) begin
          // Chain straight into the next START so queued bytes leave gap-free.
          if (!tx_empty) begin
            tx_pop   = 1'b1;
            tx_sh_d  = tx_rdata;
            tx_cnt_d = div_eff;
            txd_d    = 1'b0;
            tx_st_d  = S_START;
          end else begin
            txd_d   = 1'b1;
            tx_st_d = S_IDLE;
          end
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      default: tx_st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      rx_st_q  <= S_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
    end else begin
      rx_st_q  <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
    end
  end

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_cnt_d = rx_cnt_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_push  = 1'b0;
    fe_set   = 1'b0;
    ovr_set  = 1'b0;
    case (rx_st_q)
      S_IDLE: begin
        // Edge detect means a low line after a bad stop bit must rise first.
        if (rx_prev_q && !rx_s) begin
          rx_st_d  = S_START;
          rx_cnt_d = half - 16'd1;
        end
      end
      S_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_s) rx_st_d = S_IDLE;
          else begin
            rx_st_d  = S_DATA;
            rx_cnt_d = div_eff;
            rx_bit_d = 3'd0;
          end
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      S_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_sh_d  = {rx_s, rx_sh_q[7:1]};
          rx_cnt_d = div_eff;
          if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      S_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_st_d = S_IDLE;
          if (!rx_s) fe_set = 1'b1;
          else if (!rx_full || rx_pop) rx_push = 1'b1;
          else ovr_set = 1'b1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      default: rx_st_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_j1_uart.sv
// Scoreboarded bench for j1_uart: register reads and serial TX frames are checked
// by monitors against expectations queued from a queue-based behavioural model.

module tb_j1_uart;
  localparam logic [15:0] BASE = 16'hF000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        io_rd = 1'b0, io_wr = 1'b0;
  logic [15:0] io_addr = 16'h0000, io_dout = 16'h0000;
  logic [15:0] io_din;
  logic        rxd_drv = 1'b1, loop = 1'b0;
  logic        txd, rxd;

  assign rxd = loop ? txd : rxd_drv;
  always #5 clk = ~clk;

  j1_uart #(.BASE(BASE), .DIV_RESET(16'd433), .FIFO_DEPTH(8)) dut (
    .sys_clk_i(clk), .sys_rst_i(rst), .io_rd(io_rd), .io_wr(io_wr),
    .io_addr(io_addr), .io_dout(io_dout), .io_din(io_din),
    .uart_rxd_i(rxd), .uart_txd_o(txd)
  );

  int n_cmp = 0, n_bad = 0;
  int cur_per = 434;
  string       rd_name_q[$];
  logic [15:0] rd_exp_q[$];
  logic [7:0]  tx_exp_q[$];
  logic [7:0]  rx_model[$];
  bit          ovr_model;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Expected STATUS from the model, assuming the transmitter has drained.
  function automatic logic [15:0] stat_exp(input bit fe);
    return {11'b0, 1'b1, fe, ovr_model, 1'b1, rx_model.size() != 0};
  endfunction

  function automatic void rx_arrive(input logic [7:0] b);
    if (rx_model.size() < 8) rx_model.push_back(b);
    else ovr_model = 1'b1;
  endfunction

  task automatic rd(input logic [15:0] addr, input logic [15:0] exp, input string nm);
    rd_name_q.push_back(nm);
    rd_exp_q.push_back(exp);
    @(posedge clk); #1;
    io_addr = addr; io_rd = 1'b1;
    @(posedge clk); #1;
    io_rd = 1'b0; io_addr = 16'h0000;
  endtask

  task automatic rd_off(input logic [1:0] off, input logic [15:0] exp, input string nm);
    rd(BASE + {13'b0, off, 1'b0}, exp, nm);
  endtask

  task automatic wr(input logic [1:0] off, input logic [15:0] data);
    @(posedge clk); #1;
    io_addr = BASE + {13'b0, off, 1'b0}; io_dout = data; io_wr = 1'b1;
    @(posedge clk); #1;
    io_wr = 1'b0; io_addr = 16'h0000;
  endtask

  task automatic wr_div(input logic [15:0] d);
    wr(2'd2, d);
    cur_per = ((d < 16'd3) ? 3 : int'(d)) + 1;
  endtask

  task automatic wr_byte(input logic [7:0] b, input bit accepted);
    if (accepted) tx_exp_q.push_back(b);
    wr(2'd0, {8'h00, b});
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tx_exp_q.delete();
    rx_model.delete();
    ovr_model = 1'b0;
    cur_per = 434;
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = fr[i];
      repeat (cur_per) @(posedge clk);
      #1;
    end
    rxd_drv = 1'b1;
    repeat (3 * cur_per) @(posedge clk);
    #1;
  endtask

  string       mon_nm;
  logic [15:0] mon_exp;
  always @(negedge clk) begin
    if (io_rd) begin
      if (rd_exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rd_unexpected: got %h, expected no read", io_din);
      end else begin
        mon_nm  = rd_name_q.pop_front();
        mon_exp = rd_exp_q.pop_front();
        chk(mon_nm, io_din, mon_exp);
      end
    end
  end

  // Serial-line monitor: decodes frames at mid-bit and checks against tx_exp_q.
  logic       tx_prev = 1'b1;
  int         tm_per;
  bit         tm_ab;
  logic [7:0] tm_b, tm_e;
  logic       tm_st, tm_sp;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && tx_prev && !txd) begin
        tm_per = cur_per;
        tm_ab  = 1'b0;
        repeat (tm_per / 2) begin @(negedge clk); if (rst) tm_ab = 1'b1; end
        tm_st = txd;
        for (int k = 0; k < 8; k++) begin
          repeat (tm_per) begin @(negedge clk); if (rst) tm_ab = 1'b1; end
          tm_b[k] = txd;
        end
        repeat (tm_per) begin @(negedge clk); if (rst) tm_ab = 1'b1; end
        tm_sp = txd;
        if (!tm_ab) begin
          if (tx_exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL tx_unexpected: got frame %h, expected none", tm_b);
          end else begin
            tm_e = tx_exp_q.pop_front();
            chk("tx_frame", {6'b0, tm_st, tm_sp, tm_b}, {6'b0, 1'b0, 1'b1, tm_e});
          end
        end
      end
      tx_prev = txd;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  fr55;
    logic [15:0] d;
    logic [7:0]  b;
    int          n;

    ovr_model = 1'b0;
    pulse_rst();
    @(negedge clk);
    chk("rst_txd", {15'b0, txd}, 16'h0001);
    rd_off(2'd1, 16'h0012, "rst_status");
    rd_off(2'd2, 16'd433, "rst_div");
    rd_off(2'd3, 16'h0000, "rst_reserved");
    rd(BASE + 16'd8, 16'h0000, "unselected");
    rd_off(2'd0, 16'h0000, "rst_data");

    wr_div(16'd9);
    rd_off(2'd2, 16'd9, "div9");
    wr(2'd3, 16'hBEEF);
    rd_off(2'd3, 16'h0000, "reserved_wr");
    repeat (3) @(posedge clk);
    fr55 = {1'b1, 8'h55, 1'b0};
    wr_byte(8'h55, 1'b1);
    @(negedge clk);
    chk("tx55_pre", {15'b0, txd}, 16'h0001);
    for (int j = 1; j <= 100; j++) begin
      @(negedge clk);
      chk($sformatf("tx55_bit%0d", (j - 1) / 10), {15'b0, txd}, {15'b0, fr55[(j - 1) / 10]});
    end
    @(negedge clk);
    chk("tx55_post", {15'b0, txd}, 16'h0001);
    repeat (5) @(posedge clk);
    rd_off(2'd1, 16'h0012, "tx_idle_status");

    loop = 1'b1;
    wr_byte(8'hA5, 1'b1);
    repeat (110) @(posedge clk);
    rd_off(2'd1, 16'h0013, "lb_status");
    rd_off(2'd0, 16'h00A5, "lb_data");
    rd_off(2'd1, 16'h0012, "lb_status2");

    for (int i = 1; i <= 9; i++) begin
      wr_byte(8'(i), 1'b1);
      rx_arrive(8'(i));
    end
    repeat (9 * 100 + 40) @(posedge clk);
    rd_off(2'd1, stat_exp(1'b0), "ovr_status");
    ovr_model = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rd_off(2'd0, (rx_model.size() != 0) ? {8'h00, rx_model.pop_front()} : 16'h0000,
             $sformatf("ovr_data%0d", i));
    end
    rd_off(2'd1, stat_exp(1'b0), "ovr_cleared");

    for (int it = 0; it < 6; it++) begin
      d = 16'($urandom_range(0, 12));
      wr_div(d);
      rd_off(2'd2, d, "rand_div");
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(0, 255));
        wr_byte(b, 1'b1);
        rx_arrive(b);
      end
      repeat (n * 10 * cur_per + 40) @(posedge clk);
      rd_off(2'd1, stat_exp(1'b0), "rand_status");
      while (rx_model.size() != 0) rd_off(2'd0, {8'h00, rx_model.pop_front()}, "rand_data");
      rd_off(2'd0, 16'h0000, "rand_empty");
      rd_off(2'd1, stat_exp(1'b0), "rand_status2");
    end

    loop = 1'b0;
    wr_div(16'd9);
    repeat (20) @(posedge clk);
    #1;
    drive_rx(8'h5A, 1'b0);
    rd_off(2'd1, stat_exp(1'b1), "fe_status");
    rd_off(2'd0, 16'h0000, "fe_data");
    rd_off(2'd1, stat_exp(1'b0), "fe_cleared");
    rxd_drv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rxd_drv = 1'b1;
    repeat (60) @(posedge clk);
    rd_off(2'd1, stat_exp(1'b0), "glitch_status");
    drive_rx(8'h3C, 1'b1);
    rx_arrive(8'h3C);
    rd_off(2'd1, stat_exp(1'b0), "rxdrv_status");
    rd_off(2'd0, {8'h00, rx_model.pop_front()}, "rxdrv_data");

    wr_byte(8'hE0, 1'b1);
    repeat (5) @(posedge clk);
    for (int i = 0; i < 8; i++) wr_byte(8'($urandom_range(0, 255)), 1'b1);
    rd_off(2'd1, 16'h0000, "txfull_status");
    wr_byte(8'h99, 1'b0);
    rd_off(2'd1, 16'h0000, "txfull_status2");
    repeat (9 * 100 + 40) @(posedge clk);
    rd_off(2'd1, 16'h0012, "txfull_drained");

    wr_byte(8'h00, 1'b0);
    repeat (40) @(posedge clk);
    pulse_rst();
    @(negedge clk);
    chk("midrst_txd", {15'b0, txd}, 16'h0001);
    rd_off(2'd1, 16'h0012, "midrst_status");
    rd_off(2'd2, 16'd433, "midrst_div");
    rd_off(2'd0, 16'h0000, "midrst_data");
    repeat (150) @(posedge clk);

    chk("tx_exp_left", 16'(tx_exp_q.size()), 16'h0000);
    chk("rd_exp_left", 16'(rd_exp_q.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/j1_uart.md
# j1_uart

Memory-mapped 8N1 UART peripheral on the J1 CPU I/O bus, directly downstream of the CPU core's `io_*` port. It decodes three registers inside the CPU's I/O window (4000H–FFFFH) and drives read data combinationally so the CPU can consume it in the same cycle as `@`. It buffers transmit and receive bytes in small FIFOs.

## Interface
- `BASE`, 16'hF000: register block base address (byte address); bits [2:0] must be 0.
- `DIV_RESET`, 16'd433: reset value of the divisor register; bit period = DIV+1 clocks.
- `FIFO_DEPTH`, 8: entries per TX and RX FIFO; power of two, ≥2.

Ports:
- `sys_clk_i` input 1: main clock.
- `sys_rst_i` input 1: reset. One clock; reset is synchronous and active-high.
- `io_rd` input 1: CPU I/O read strobe.
- `io_wr` input 1: CPU I/O write strobe.
- `io_addr` input 16: CPU I/O byte address.
- `io_dout` input 16: CPU write data.
- `io_din` output 16: read data to the CPU; combinational.
- `uart_rxd_i` input 1: serial receive; asynchronous, idle high.
- `uart_txd_o` output 1: serial transmit; idle high.

## Operation
- The block is selected when `io_addr[15:3] == BASE[15:3]`. The register offset is `io_addr[2:1]`.
  - 0 = DATA
  - 1 = STATUS
  - 2 = DIV
  - 3 = reserved: reads 0, writes are ignored.
- `io_din` is 16'h0000 whenever the block is not selected, so it can be ORed with other peripherals. It is independent of `io_rd`.
- DATA register:
  - Read returns `{8'h00, RX head}`, or 0 if the RX FIFO is empty.
  - A read with `io_rd` pops the RX FIFO if it is non-empty.
  - A write pushes `io_dout[7:0]` into the TX FIFO. If the TX FIFO is full, the write is silently dropped.
- STATUS register (read-only; bits [15:5] are 0):
  - bit0 `rx_valid`: RX FIFO non-empty.
  - bit1 `tx_ready`: TX FIFO not full.
  - bit2 `rx_overrun`: sticky.
  - bit3 `frame_err`: sticky.
  - bit4 `tx_idle`: TX FIFO empty and transmitter IDLE.
  - A read with `io_rd` clears bits 2 and 3 at the clock edge. If a new error occurs in the same cycle, the bit stays set.
- DIV register: read/write, all 16 bits. Values below 3 behave as 3. A new value takes effect at the next bit-counter reload.
- TX FSM: IDLE → START → DATA(8 bits, LSB first) → STOP → IDLE.
  - Each state or bit lasts DIV+1 clocks.
  - IDLE pops the TX FIFO when it is non-empty and enters START.
  - From STOP, the FSM goes directly to START if the FIFO is non-empty; there are no idle gaps.
- RX path:
  - `uart_rxd_i` passes through a 2-flop synchronizer.
  - FSM: IDLE → START → DATA → STOP.
  - IDLE waits for a synchronized falling edge.
  - START waits (DIV+1)/2 clocks, then samples. If the sample is high, the FSM returns to IDLE (glitch). If low, it continues.
  - DATA takes 8 samples spaced DIV+1 clocks apart, LSB first.
  - STOP takes a sample after DIV+1 clocks:
    - Stop = 0: set `frame_err`, discard the byte.
    - Stop = 1: push the byte into the RX FIFO if there is space, or if a pop occurs in the same cycle. Otherwise set `rx_overrun` and discard the byte.
  - The FSM then returns to IDLE. It waits for the line to go high before it can detect the next start bit.
- FIFO counters: a simultaneous push and pop leaves the count unchanged and keeps both data paths correct. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset (held ≥1 cycle) sets:
  - `uart_txd_o` = 1, both FSMs IDLE, FIFOs empty.
  - STATUS = 16'h0012, DIV = DIV_RESET.
  - Synchronizer flops = 1.
- Outputs are valid the cycle after `sys_rst_i` deasserts.
- Reset mid-frame aborts both frames. `uart_txd_o` is high after that edge.
- Register reads: zero-latency combinational path from `io_addr` to `io_din`. Pops and status clears happen at the edge that ends the read cycle.
- Writes are captured at the edge ending the cycle where `io_wr` = 1.
- TX latency: for a DATA write in cycle c with the transmitter idle, `uart_txd_o` falls at the edge ending c+1. The frame lasts 10×(DIV+1) clocks.
- RX: `rx_valid` rises at the edge after the stop-bit sample, which is about 3 clocks of synchronizer/sample latency past the stop-bit midpoint.
- `tx_ready` and `rx_valid` reflect FIFO state after each edge, with no extra pipeline.

## Test plan
- Reset values: read offset 1 → 16'h0012; read offset 2 → 16'd433; `uart_txd_o` = 1; read at BASE+8 → 0.
- Write DIV=9, then DATA=0x55 → `uart_txd_o` bits 0,1,0,1,0,1,0,1,0,1, each exactly 10 clocks, first fall one edge after the write; then STATUS bit4 = 1.
- Loopback `txd` → `rxd` with DIV=9, write 0xA5 → `rx_valid` within about 105 clocks; DATA read returns 16'h00A5; next STATUS read returns 16'h0012.
- Loopback, 9 bytes 0x01..0x09 with no reads, FIFO_DEPTH 8 → STATUS bit2 = 1. Eight reads return 0x01..0x08; the ninth returns 0. The next STATUS read shows bit2 = 0.
- Drive an rxd frame with stop bit 0 → `frame_err` = 1 and RX FIFO empty. Drive a 3-clock low glitch → no byte and no error.
- Write 9 bytes back-to-back while TX is busy → `tx_ready` drops at count 8; the ninth byte is dropped. Assert reset mid-frame → `txd` = 1 next cycle and STATUS = 16'h0012.
